load_store_unit: RTL and testbench

- Initiator side of the data-memory access interface; sits between the MEM pipeline stage and the word-indexed data memory.
- Computes the effective address, validates the request and issues exactly one memory request per load/store. Holds the request stable until the memory acknowledges.
- Narrows and extends load data for lb/lh/lw/lbu/lhu and masks store data for sb/sh/sw.
- Drives a busy/stall signal back to the pipeline.

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, validates and issues one word-memory request
// per load/store, and narrows/extends the data. Define LSU_TIMEOUT_EN to abort stalled requests.
module load_store_unit #(
    parameter int unsigned ADDR_DEPTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [31:0] store_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        mem_req,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [5:0]  mem_opcode,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data
);

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;

    typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

    state_e      state;
    logic [31:0] ea;
    logic        is_load_op;
    logic        is_store_op;
    logic        req_valid;
    logic [31:0] store_masked;
    logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_cnt;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign ea = base + {{16{offset[15]}}, offset};

    always_comb begin
        is_load_op  = 1'b0;
        is_store_op = 1'b0;
        case (opcode)
            OpLb, OpLh, OpLw, OpLbu, OpLhu: is_load_op  = 1'b1;
            OpSb, OpSh, OpSw:               is_store_op = 1'b1;
            default: ;
        endcase
    end

    assign req_valid = ((MemRead && !MemWrite && is_load_op) ||
                        (MemWrite && !MemRead && is_store_op)) &&
                       (ea < 32'(ADDR_DEPTH));

    always_comb begin
        store_masked = store_data;
        case (opcode)
            OpSb:    store_masked = {24'b0, store_data[7:0]};
            OpSh:    store_masked = {16'b0, store_data[15:0]};
            default: store_masked = store_data;
        endcase
    end

    // Extension keys off the latched opcode, which is stable for the whole request.
    always_comb begin
        load_ext = mem_rdata;
        case (mem_opcode)
            OpLb:    load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            OpLbu:   load_ext = {24'b0, mem_rdata[7:0]};
            OpLh:    load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            OpLhu:   load_ext = {16'b0, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            mem_req        <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_opcode     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            load_data      <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (req_valid) begin
                            state          <= StReq;
                            mem_req        <= 1'b1;
                            mem_read       <= MemRead;
                            mem_write      <= MemWrite;
                            mem_address    <= ea;
                            mem_write_data <= store_masked;
                            mem_opcode     <= opcode;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt        <= '0;
`endif
                        end else begin
                            state <= StErr;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    // Acknowledge takes priority over a same-cycle timeout.
                    if (mem_ready) begin
                        if (mem_read) begin
                            load_data <= load_ext;
                        end
                        state     <= StDone;
                        mem_req   <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == TmoLast) begin
                        state     <= StErr;
                        mem_req   <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                StDone, StErr: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
                default: begin
                    state     <= StIdle;
                    mem_req   <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, load extension, store masking, stalls,
// rejected requests, start-while-busy, reset mid-request and (optionally) timeout.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [15:0] offset;
    logic [31:0] store_data;
    logic        MemRead;
    logic        MemWrite;
    logic        mem_req;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [5:0]  mem_opcode;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_data;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(
        .ADDR_DEPTH    (256),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .opcode        (opcode),
        .base          (base),
        .offset        (offset),
        .store_data    (store_data),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .mem_req       (mem_req),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_opcode    (mem_opcode),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .load_data     (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one start strobe; returns at the negedge of the first cycle after acceptance.
    task automatic issue(input logic [5:0] op, input logic [31:0] b, input logic [15:0] off,
                         input logic [31:0] sd, input logic mr, input logic mw);
        opcode     = op;
        base       = b;
        offset     = off;
        store_data = sd;
        MemRead    = mr;
        MemWrite   = mw;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Load with mem_ready tied high; checks done timing and the extended result.
    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] rd,
                           input logic [31:0] exp);
        mem_ready = 1'b1;
        mem_rdata = rd;
        issue(op, 32'h0000_0008, 16'h0000, 32'h0, 1'b1, 1'b0);
        check({tag, "_req"}, {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        check({tag, "_done"}, {30'b0, done, error}, 32'b10);
        check({tag, "_data"}, load_data, exp);
        @(negedge clk);
    endtask

    // Rejected request: done+error one cycle after start, never a memory request.
    task automatic do_reject(input string tag, input logic [5:0] op, input logic [31:0] b,
                             input logic [15:0] off, input logic mr, input logic mw,
                             input logic [31:0] exp_ld);
        mem_ready = 1'b1;
        issue(op, b, off, 32'h0, mr, mw);
        check({tag, "_err"}, {28'b0, mem_req, busy, done, error}, 32'b0111);
        check({tag, "_ld"}, load_data, exp_ld);
        @(negedge clk);
        check({tag, "_idle"}, {29'b0, mem_req, busy, done}, 32'b000);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        opcode     = 6'h0;
        base       = 32'h0;
        offset     = 16'h0;
        store_data = 32'h0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ctl", {26'b0, mem_req, mem_read, mem_write, busy, done, error}, 32'h0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        check("rst_op", {26'b0, mem_opcode}, 32'h0);
        check("rst_ld", load_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // lw: ea = 0x10 + 4
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        issue(6'h23, 32'h0000_0010, 16'h0004, 32'h0, 1'b1, 1'b0);
        check("lw_req", {28'b0, mem_req, mem_read, mem_write, busy}, 32'b1101);
        check("lw_addr", mem_address, 32'h14);
        check("lw_op", {26'b0, mem_opcode}, 32'h23);
        check("lw_nodone", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("lw_done", {29'b0, mem_req, done, error}, 32'b010);
        check("lw_data", load_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lw_idle", {30'b0, busy, done}, 32'b00);

        do_load("lb", 6'h20, 32'h0000_00F0, 32'hFFFF_FFF0);
        do_load("lbu", 6'h24, 32'h0000_00F0, 32'h0000_00F0);
        do_load("lh", 6'h21, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lhu", 6'h25, 32'hABCD_8001, 32'h0000_8001);

        // sh with three stall cycles; ea = 0x20 + (-1)
        mem_ready = 1'b0;
        issue(6'h29, 32'h0000_0020, 16'hFFFF, 32'h1234_5678, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("sh_req", {28'b0, mem_req, mem_read, mem_write, done}, 32'b1010);
            check("sh_addr", mem_address, 32'h1F);
            check("sh_wdata", mem_write_data, 32'h0000_5678);
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        check("sh_done", {29'b0, mem_req, done, error}, 32'b010);
        check("sh_ld", load_data, 32'h0000_8001);
        @(negedge clk);

        mem_ready = 1'b1;
        issue(6'h28, 32'h0000_0001, 16'h0000, 32'hAABB_CCDD, 1'b0, 1'b1);
        check("sb_wdata", mem_write_data, 32'h0000_00DD);
        @(negedge clk);
        check("sb_done", {30'b0, done, error}, 32'b10);
        @(negedge clk);
        issue(6'h2B, 32'h0000_00FF, 16'h0000, 32'hAABB_CCDD, 1'b0, 1'b1);
        check("sw_wdata", mem_write_data, 32'hAABB_CCDD);
        check("sw_addr", mem_address, 32'hFF);
        @(negedge clk);
        check("sw_done", {30'b0, done, error}, 32'b10);
        @(negedge clk);

        do_reject("ea_oob", 6'h23, 32'h0000_00FF, 16'h0001, 1'b1, 1'b0, 32'h0000_8001);
        do_reject("rw_both", 6'h23, 32'h0000_0004, 16'h0000, 1'b1, 1'b1, 32'h0000_8001);
        do_reject("sw_read", 6'h2B, 32'h0000_0004, 16'h0000, 1'b1, 1'b0, 32'h0000_8001);
        do_reject("bad_op", 6'h22, 32'h0000_0004, 16'h0000, 1'b1, 1'b0, 32'h0000_8001);

        // start pulsed while busy must be neither taken nor queued
        mem_ready = 1'b0;
        mem_rdata = 32'h0000_0055;
        issue(6'h23, 32'h0000_0030, 16'h0000, 32'h0, 1'b1, 1'b0);
        issue(6'h28, 32'h0000_0040, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("busy_addr", mem_address, 32'h30);
        check("busy_rw", {30'b0, mem_read, mem_write}, 32'b10);
        mem_ready = 1'b1;
        @(negedge clk);
        check("busy_done", {30'b0, done, error}, 32'b10);
        check("busy_ld", load_data, 32'h0000_0055);
        @(negedge clk);
        @(negedge clk);
        check("busy_noq", {29'b0, mem_req, busy, done}, 32'b000);

`ifdef LSU_TIMEOUT_EN
        mem_ready = 1'b0;
        issue(6'h23, 32'h0000_0010, 16'h0000, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("tmo_req", {30'b0, mem_req, done}, 32'b10);
            @(negedge clk);
        end
        check("tmo_err", {29'b0, mem_req, done, error}, 32'b011);
        check("tmo_ld", load_data, 32'h0000_0055);
        @(negedge clk);
        check("tmo_idle", {30'b0, busy, done}, 32'b00);
`endif

        // asynchronous reset in the middle of a stalled request
        mem_ready = 1'b0;
        issue(6'h23, 32'h0000_0010, 16'h0000, 32'h0, 1'b1, 1'b0);
        check("mid_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {27'b0, mem_req, mem_read, busy, done, error}, 32'h0);
        check("mid_rst_addr", mem_address, 32'h0);
        check("mid_rst_ld", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst1", {29'b0, mem_req, busy, done}, 32'b000);
        @(negedge clk);
        check("post_rst2", {29'b0, mem_req, busy, done}, 32'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
